// File: rtl/multdiv_ctrl.sv
// Multicycle signed mul/div sequencer: stalls the pipeline for a fixed 32-step run, then
// presents result/exc/rstatus for one cycle. Define MULTDIV_DIV_EN to include the divider.
module multdiv_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  opcode,
  input  logic [4:0]  ALU_op,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic        exc,
  output logic [31:0] rstatus
);

  localparam logic [4:0]  OpRtype  = 5'b00000;
  localparam logic [4:0]  AluMul   = 5'b00110;
  localparam logic [31:0] RsMulOvf = 32'd4;
`ifdef MULTDIV_DIV_EN
  localparam logic [4:0]  AluDiv    = 5'b00111;
  localparam logic [31:0] RsDivZero = 32'd5;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_q, neg_d;
  logic        done_q, done_d;
  logic        exc_q, exc_d;
  logic [31:0] result_q, result_d;
  logic [31:0] rstatus_q, rstatus_d;

  logic        is_mul, is_div, req;
  logic [31:0] abs_a, abs_b;

  assign is_mul = en && (opcode == OpRtype) && (ALU_op == AluMul);
`ifdef MULTDIV_DIV_EN
  logic op_div_q, op_div_d;
  logic div_zero;
  assign is_div   = en && (opcode == OpRtype) && (ALU_op == AluDiv);
  assign div_zero = is_div && (operandB == 32'd0);
`else
  assign is_div = 1'b0;
`endif
  assign req   = is_mul || is_div;
  assign abs_a = operandA[31] ? -operandA : operandA;
  assign abs_b = operandB[31] ? -operandB : operandB;

  // Multiplier walks b_q MSB-first, so the accumulator shifts left each step.
  logic [63:0] mul_acc, mul_prod;
  logic        mul_ovf;
  assign mul_acc  = (acc_q << 1) + (b_q[31] ? {32'd0, a_q} : 64'd0);
  assign mul_prod = neg_q ? -mul_acc : mul_acc;
  assign mul_ovf  = mul_prod[63:32] != {32{mul_prod[31]}};

`ifdef MULTDIV_DIV_EN
  // Restoring divider: remainder in acc_q[31:0], dividend shifts out of a_q as quotient shifts in.
  logic [32:0] rem_sh, rem_diff;
  logic        q_bit;
  logic [31:0] rem_nxt, quot_nxt, div_res;
  assign rem_sh   = {acc_q[31:0], a_q[31]};
  assign rem_diff = rem_sh - {1'b0, b_q};
  assign q_bit    = ~rem_diff[32];
  assign rem_nxt  = q_bit ? rem_diff[31:0] : rem_sh[31:0];
  assign quot_nxt = {a_q[30:0], q_bit};
  assign div_res  = neg_q ? -quot_nxt : quot_nxt;
`endif

  logic [63:0] step_acc;
  logic [31:0] step_a, step_b, fin_result, fin_rs;
  logic        fin_exc;

  always_comb begin
    step_acc   = mul_acc;
    step_a     = a_q;
    step_b     = b_q << 1;
    fin_result = mul_prod[31:0];
    fin_exc    = mul_ovf;
    fin_rs     = mul_ovf ? RsMulOvf : 32'd0;
`ifdef MULTDIV_DIV_EN
    if (op_div_q) begin
      step_acc   = {32'd0, rem_nxt};
      step_a     = quot_nxt;
      step_b     = b_q;
      fin_result = div_res;
      fin_exc    = 1'b0;
      fin_rs     = 32'd0;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    done_d    = 1'b0;
    exc_d     = 1'b0;
    result_d  = 32'd0;
    rstatus_d = 32'd0;
    stall     = 1'b0;
`ifdef MULTDIV_DIV_EN
    op_div_d  = op_div_q;
`endif
    case (state_q)
      StIdle: begin
        if (req) begin
          stall   = 1'b1;
          a_d     = abs_a;
          b_d     = abs_b;
          neg_d   = operandA[31] ^ operandB[31];
          acc_d   = 64'd0;
          cnt_d   = 5'd0;
          state_d = StRun;
`ifdef MULTDIV_DIV_EN
          op_div_d = is_div;
          if (div_zero) begin
            state_d   = StDone;
            done_d    = 1'b1;
            exc_d     = 1'b1;
            rstatus_d = RsDivZero;
          end
`endif
        end
      end
      StRun: begin
        stall = 1'b1;
        cnt_d = cnt_q + 5'd1;
        acc_d = step_acc;
        a_d   = step_a;
        b_d   = step_b;
        if (cnt_q == 5'd31) begin
          state_d   = StDone;
          done_d    = 1'b1;
          result_d  = fin_result;
          exc_d     = fin_exc;
          rstatus_d = fin_rs;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      acc_q     <= 64'd0;
      neg_q     <= 1'b0;
      done_q    <= 1'b0;
      exc_q     <= 1'b0;
      result_q  <= 32'd0;
      rstatus_q <= 32'd0;
`ifdef MULTDIV_DIV_EN
      op_div_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      done_q    <= done_d;
      exc_q     <= exc_d;
      result_q  <= result_d;
      rstatus_q <= rstatus_d;
`ifdef MULTDIV_DIV_EN
      op_div_q  <= op_div_d;
`endif
    end
  end

  assign done    = done_q;
  assign exc     = exc_q;
  assign result  = result_q;
  assign rstatus = rstatus_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: a latency/arithmetic reference model checked every
// cycle, plus directed operations with hand-computed results.
module tb_multdiv_ctrl;

  logic        clock = 1'b0;
  logic        reset, en;
  logic [4:0]  opcode, ALU_op;
  logic [31:0] operandA, operandB;
  logic        stall, done, exc;
  logic [31:0] result, rstatus;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

`ifdef MULTDIV_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif
  localparam logic [4:0] AluMul = 5'b00110;
  localparam logic [4:0] AluDiv = 5'b00111;

  always #5 clock = ~clock;

  multdiv_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .opcode   (opcode),
    .ALU_op   (ALU_op),
    .operandA (operandA),
    .operandB (operandB),
    .stall    (stall),
    .done     (done),
    .result   (result),
    .exc      (exc),
    .rstatus  (rstatus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: signed arithmetic on 64-bit integers and the architectural latency.
  function automatic void ref_op(input logic [4:0] alu, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] r, output logic e,
                                 output logic [31:0] rs, output int lat);
    longint p;
    if (alu == AluMul) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      r   = p[31:0];
      e   = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      rs  = e ? 32'd4 : 32'd0;
      lat = 33;
    end else if (b == 32'd0) begin
      r = 32'd0; e = 1'b1; rs = 32'd5; lat = 1;
    end else begin
      p   = longint'($signed(a)) / longint'($signed(b));
      r   = p[31:0];
      e   = 1'b0;
      rs  = 32'd0;
      lat = 33;
    end
  endfunction

  // Per-cycle compare process.
  bit          m_busy = 1'b0;
  int          m_k, m_lat, cyc_n = 0;
  logic [31:0] m_r, m_rs, e_r, e_rs;
  logic        m_e, e_e, e_stall, e_done, req_m;

  initial begin
    forever begin
      @(negedge clock);
      cyc_n++;
      if (chk_en) begin
        req_m = en && (opcode == 5'd0) && ((ALU_op == AluMul) || (DivEn && ALU_op == AluDiv));
        e_done = 1'b0; e_r = 32'd0; e_e = 1'b0; e_rs = 32'd0;
        if (!m_busy) begin
          e_stall = req_m;
          if (req_m && !reset) begin
            ref_op(ALU_op, operandA, operandB, m_r, m_e, m_rs, m_lat);
            m_busy = 1'b1;
            m_k    = 0;
          end
        end else begin
          m_k++;
          if (m_k < m_lat) begin
            e_stall = 1'b1;
          end else begin
            e_stall = 1'b0; e_done = 1'b1; e_r = m_r; e_e = m_e; e_rs = m_rs;
            m_busy  = 1'b0;
          end
        end
        if (reset) m_busy = 1'b0;
        check($sformatf("c%0d_stall", cyc_n), 64'(stall), 64'(e_stall));
        check($sformatf("c%0d_done", cyc_n), 64'(done), 64'(e_done));
        check($sformatf("c%0d_result", cyc_n), 64'(result), 64'(e_r));
        check($sformatf("c%0d_exc", cyc_n), 64'(exc), 64'(e_e));
        check($sformatf("c%0d_rstatus", cyc_n), 64'(rstatus), 64'(e_rs));
      end
    end
  end

  // One instruction for a single cycle, then scrambled operands; waits for done.
  task automatic run_op(input string name, input logic [4:0] alu, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ee,
                        input logic [31:0] ers, input int elat);
    int lat;
    bit seen;
    @(posedge clock); #1;
    en = 1'b1; opcode = 5'd0; ALU_op = alu; operandA = a; operandB = b;
    @(negedge clock);
    check({name, "_stall_T"}, 64'(stall), 64'd1);
    @(posedge clock); #1;
    en = 1'b0; operandA = $urandom; operandB = $urandom;
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clock);
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check({name, "_latency"}, 64'(lat), 64'(elat));
    check({name, "_result"}, 64'(result), 64'(er));
    check({name, "_exc"}, 64'(exc), 64'(ee));
    check({name, "_rstatus"}, 64'(rstatus), 64'(ers));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; en = 1'b0; opcode = 5'd0; ALU_op = 5'd0; operandA = 32'd0; operandB = 32'd0;
    repeat (2) @(posedge clock);
    #1 chk_en = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_exc", 64'(exc), 64'd0);
    check("reset_rstatus", 64'(rstatus), 64'd0);

    run_op("mul_7_m6", AluMul, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0, 32'd0, 33);
    run_op("mul_ovf", AluMul, 32'h00010000, 32'h00010000, 32'd0, 1'b1, 32'd4, 33);
    run_op("mul_zero", AluMul, 32'd0, 32'h00012345, 32'd0, 1'b0, 32'd0, 33);
    run_op("mul_min_1", AluMul, 32'h80000000, 32'd1, 32'h80000000, 1'b0, 32'd0, 33);
    run_op("mul_min_m1", AluMul, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 32'd4, 33);
    run_op("mul_max_2", AluMul, 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1, 32'd4, 33);
    run_op("mul_m3_5", AluMul, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 1'b0, 32'd0, 33);

    // Bubble: mul encoding with en low must not start.
    @(posedge clock); #1;
    en = 1'b0; opcode = 5'd0; ALU_op = AluMul; operandA = 32'd3; operandB = 32'd3;
    repeat (3) begin
      @(negedge clock);
      check("bubble_stall", 64'(stall), 64'd0);
      check("bubble_done", 64'(done), 64'd0);
    end

    // Reset partway through a mul aborts it silently.
    @(posedge clock); #1;
    en = 1'b1; opcode = 5'd0; ALU_op = AluMul; operandA = 32'd3; operandB = 32'd4;
    @(posedge clock); #1 en = 1'b0;
    repeat (9) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("rst_abort_stall", 64'(stall), 64'd0);
    check("rst_abort_done", 64'(done), 64'd0);
    run_op("mul_after_rst", AluMul, 32'hFFFFFFFD, 32'd9, 32'hFFFFFFE5, 1'b0, 32'd0, 33);

    // Request held across completion: the DONE-cycle request is ignored, then restarts.
    @(posedge clock); #1;
    en = 1'b1; opcode = 5'd0; ALU_op = AluMul; operandA = 32'd11; operandB = 32'hFFFFFFF9;
    repeat (70) @(posedge clock);
    #1 en = 1'b0;
    repeat (40) @(posedge clock);

`ifdef MULTDIV_DIV_EN
    run_op("div_m100_7", AluDiv, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 1'b0, 32'd0, 33);
    run_op("div_min_m1", AluDiv, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 32'd0, 33);
    run_op("div_5_0", AluDiv, 32'd5, 32'd0, 32'd0, 1'b1, 32'd5, 1);
    run_op("div_7_m2", AluDiv, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 32'd0, 33);
    run_op("div_m1_min", AluDiv, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 32'd0, 33);
    run_op("div_max_1", AluDiv, 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 1'b0, 32'd0, 33);
`else
    @(posedge clock); #1;
    en = 1'b1; opcode = 5'd0; ALU_op = AluDiv; operandA = 32'd5; operandB = 32'd0;
    repeat (4) begin
      @(negedge clock);
      check("nodiv_stall", 64'(stall), 64'd0);
      check("nodiv_done", 64'(done), 64'd0);
    end
    @(posedge clock); #1 en = 1'b0;
`endif

    repeat (3) @(posedge clock);
    #1 chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
